// File: rtl/barret_reduce_pipe.sv
// Pipelined Barrett reducer: dout_r = din_a mod Q for odd Q, 3-cycle latency, valid/ready with backpressure.
// Optional feature macro: BARRET_RANGE_CHK_EN adds out_oor (operand >= Q*Q), pipelined with the data.
module barret_reduce_pipe #(
  parameter int Q  = 877,
  parameter int QW = $clog2(Q),
  parameter int DW = 19,
  parameter int KW = 2 * QW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] din_a,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [QW-1:0] dout_r
`ifdef BARRET_RANGE_CHK_EN
  ,
  output logic          out_oor
`endif
);

  localparam int PW = DW + KW;
  localparam int MW = DW + QW;
  localparam int TW = QW + 2;

  localparam logic [63:0] Q_64  = 64'(Q);
  localparam logic [63:0] MU_64 = (64'd1 << KW) / Q_64;
  localparam logic [KW-1:0] MU  = MU_64[KW-1:0];
  localparam logic [QW-1:0] Q_W = Q_64[QW-1:0];
  localparam logic [MW-1:0] Q_M = {{DW{1'b0}}, Q_W};
  localparam logic [TW-1:0] Q_T  = {2'b00, Q_W};
  localparam logic [TW-1:0] Q2_T = {1'b0, Q_W, 1'b0};

  // t < 3Q, so at most two subtractions of Q bring it into [0, Q-1]
  function automatic logic [QW-1:0] final_correct(input logic [TW-1:0] t);
    logic [TW-1:0] r;
    if (t >= Q2_T) begin
      r = t - Q2_T;
    end else if (t >= Q_T) begin
      r = t - Q_T;
    end else begin
      r = t;
    end
    return QW'(r);
  endfunction

  logic          v1_r, v2_r;
  logic [DW-1:0] x1_r;
  logic [PW-1:0] p1_r;
  logic [TW-1:0] t2_r;
  logic          stall_s, en1_s, en2_s, en3_s, in_xfer_s;
  logic [PW-1:0] p_s;
  logic [DW-1:0] q_est_s;
  logic [MW-1:0] qq_s;
  logic [TW-1:0] t_s;

  // A stage may load whenever it is empty or the stage after it moves, so bubbles collapse under stall
  assign stall_s   = out_valid & ~out_ready;
  assign en3_s     = ~stall_s;
  assign en2_s     = ~v2_r | en3_s;
  assign en1_s     = ~v1_r | en2_s;
  assign in_ready  = en3_s;
  assign in_xfer_s = in_valid & en3_s;

  assign p_s     = {{KW{1'b0}}, din_a} * {{DW{1'b0}}, MU};
  assign q_est_s = DW'(p1_r >> KW);
  assign qq_s    = {{QW{1'b0}}, q_est_s} * Q_M;
  assign t_s     = TW'({{QW{1'b0}}, x1_r} - qq_s);

`ifdef BARRET_RANGE_CHK_EN
  localparam logic [63:0] QQ_64 = Q_64 * Q_64;
  logic oor1_r, oor2_r;
  logic oor_s;
  assign oor_s = ({{(64-DW){1'b0}}, din_a} >= QQ_64);
`endif

  // Stage 1: operand and its product with MU
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r <= 1'b0;
      x1_r <= {DW{1'b0}};
      p1_r <= {PW{1'b0}};
`ifdef BARRET_RANGE_CHK_EN
      oor1_r <= 1'b0;
`endif
    end else if (en1_s) begin
      v1_r <= in_xfer_s;
      if (in_xfer_s) begin
        x1_r <= din_a;
        p1_r <= p_s;
`ifdef BARRET_RANGE_CHK_EN
        oor1_r <= oor_s;
`endif
      end
    end
  end

  // Stage 2: partial remainder t = x - floor(p / 2^k) * Q
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_r <= 1'b0;
      t2_r <= {TW{1'b0}};
`ifdef BARRET_RANGE_CHK_EN
      oor2_r <= 1'b0;
`endif
    end else if (en2_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        t2_r <= t_s;
`ifdef BARRET_RANGE_CHK_EN
        oor2_r <= oor1_r;
`endif
      end
    end
  end

  // Stage 3: final correction into [0, Q-1]; held while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      dout_r    <= {QW{1'b0}};
`ifdef BARRET_RANGE_CHK_EN
      out_oor   <= 1'b0;
`endif
    end else if (en3_s) begin
      out_valid <= v2_r;
      if (v2_r) begin
        dout_r <= final_correct(t2_r);
`ifdef BARRET_RANGE_CHK_EN
        out_oor <= oor2_r;
`endif
      end
    end
  end

endmodule

// File: tb/tb_barret_reduce_pipe.sv
// Scoreboard bench for barret_reduce_pipe: expected residues are queued at input transfer, compared at output transfer.
module tb_barret_reduce_pipe;

  localparam int Q  = 877;
  localparam int QW = 10;
  localparam int DW = 19;
  localparam int KW = 20;

  logic          clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] din_a;
  logic [QW-1:0] dout_r;
  logic          out_oor;

  typedef struct {
    logic [QW-1:0] r;
    logic          oor;
    int            c;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc_n    = 0;

  barret_reduce_pipe #(.Q(Q), .QW(QW), .DW(DW), .KW(KW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .din_a    (din_a),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout_r   (dout_r)
`ifdef BARRET_RANGE_CHK_EN
    ,
    .out_oor  (out_oor)
`endif
  );

`ifndef BARRET_RANGE_CHK_EN
  assign out_oor = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock: drive on the falling edge, sample 1 ns later, then wait for the rising edge.
  task automatic cyc(input logic iv, input logic [DW-1:0] d, input logic ordy,
                     output logic ixf, output logic oxf, output logic [QW-1:0] res,
                     output logic ov, output logic ir, output logic oo);
    @(negedge clk);
    in_valid  = iv;
    din_a     = d;
    out_ready = ordy;
    #1;
    ixf = iv & in_ready;
    oxf = out_valid & ordy;
    res = dout_r;
    ov  = out_valid;
    ir  = in_ready;
    oo  = out_oor;
    @(posedge clk);
    cyc_n++;
  endtask

  task automatic push_model(input logic [DW-1:0] d);
    exp_t e;
    e.r   = QW'(int'(d) % Q);
    e.oor = (longint'(d) >= longint'(Q) * longint'(Q));
    e.c   = cyc_n;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; din_a = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (dout_r !== 10'd0) begin failures++; $display("FAIL reset_dout got=%0d exp=0", dout_r); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_sweep();
    int sent = 0; int guard = 0; exp_t e;
    logic ixf, oxf, ov, ir, oo; logic [QW-1:0] res; logic [DW-1:0] d;
    while ((sent < Q || sb.size() > 0) && guard < Q + 50) begin
      d = DW'(sent);
      cyc(sent < Q, d, 1'b1, ixf, oxf, res, ov, ir, oo);
      if (oxf) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL sweep_extra got=%0d exp=none", res); end
        else begin
          e = sb.pop_front();
          if (res !== e.r) begin failures++; $display("FAIL sweep_value got=%0d exp=%0d", res, e.r); end
          checks++;
          if (cyc_n - e.c != 3) begin failures++; $display("FAIL sweep_latency got=%0d exp=3", cyc_n - e.c); end
        end
      end
      if (ixf) begin push_model(d); sent++; end
      guard++;
    end
    checks++; if (sb.size() != 0 || sent != Q) begin failures++; $display("FAIL sweep_timeout got=%0d exp=%0d", sent, Q); end
  endtask

  task automatic test_corner();
    logic [DW-1:0] vals [6];
    logic [QW-1:0] exps [6];
    int sent = 0; int guard = 0; exp_t e;
    logic ixf, oxf, ov, ir, oo; logic [QW-1:0] res;
    vals = '{19'd877, 19'd1754, 19'd524287, 19'd0, 19'd876, 19'd523569};
    exps = '{10'd0, 10'd0, 10'd718, 10'd0, 10'd876, 10'd0};
    while ((sent < 6 || sb.size() > 0) && guard < 40) begin
      cyc(sent < 6, vals[sent % 6], 1'b1, ixf, oxf, res, ov, ir, oo);
      if (oxf) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL corner_extra got=%0d exp=none", res); end
        else begin
          e = sb.pop_front();
          if (res !== e.r) begin failures++; $display("FAIL corner_value got=%0d exp=%0d", res, e.r); end
        end
      end
      if (ixf) begin
        e.r = exps[sent]; e.oor = 1'b0; e.c = cyc_n;
        sb.push_back(e);
        sent++;
      end
      guard++;
    end
    checks++; if (sb.size() != 0 || sent != 6) begin failures++; $display("FAIL corner_timeout got=%0d exp=6", sent); end
  endtask

  task automatic test_back_to_back();
    int sent = 0; int j = 0; exp_t e;
    logic ixf, oxf, ov, ir, oo, ordy, exp_ir; logic [QW-1:0] res; logic [DW-1:0] d;
    while ((sent < 16 || sb.size() > 0) && j < 100) begin
      ordy   = !(j >= 5 && j <= 9);
      exp_ir = ordy;
      d      = DW'((sent * 32749 + 12345) % 524288);
      cyc(sent < 16, d, ordy, ixf, oxf, res, ov, ir, oo);
      checks++;
      if (ir !== exp_ir) begin failures++; $display("FAIL b2b_in_ready cycle=%0d got=%0b exp=%0b", j, ir, exp_ir); end
      if (ov && !ordy) begin
        checks++;
        if (sb.size() == 0 || res !== sb[0].r) begin failures++; $display("FAIL b2b_hold got=%0d exp=%0d", res, (sb.size() > 0) ? sb[0].r : 10'd0); end
      end
      if (oxf) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL b2b_extra got=%0d exp=none", res); end
        else begin
          e = sb.pop_front();
          if (res !== e.r) begin failures++; $display("FAIL b2b_value got=%0d exp=%0d", res, e.r); end
        end
      end
      if (ixf) begin push_model(d); sent++; end
      j++;
    end
    checks++; if (sb.size() != 0 || sent != 16) begin failures++; $display("FAIL b2b_timeout got=%0d exp=16", sent); end
  endtask

  task automatic test_random();
    int sent = 0; int guard = 0; int got = 0; exp_t e;
    logic ixf, oxf, ov, ir, oo, iv, ordy; logic [QW-1:0] res; logic [DW-1:0] d;
    while ((sent < 10000 || sb.size() > 0) && guard < 70000) begin
      iv   = (sent < 10000) && ($urandom_range(0, 1) == 1);
      ordy = ($urandom_range(0, 1) == 1);
      d    = iv ? DW'($urandom) : 'x;
      cyc(iv, d, ordy, ixf, oxf, res, ov, ir, oo);
      if (oxf) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL rand_extra got=%0d exp=none", res); end
        else begin
          e = sb.pop_front();
          got++;
          if (res !== e.r) begin failures++; $display("FAIL rand_value got=%0d exp=%0d", res, e.r); end
`ifdef BARRET_RANGE_CHK_EN
          checks++;
          if (oo !== e.oor) begin failures++; $display("FAIL rand_oor got=%0b exp=%0b", oo, e.oor); end
`endif
        end
      end
      if (ixf) begin push_model(d); sent++; end
      guard++;
    end
    checks++; if (got != 10000 || sb.size() != 0) begin failures++; $display("FAIL rand_count got=%0d exp=10000", got); end
  endtask

  task automatic test_mid_reset();
    int guard = 0; int got = 0; exp_t e;
    logic ixf, oxf, ov, ir, oo; logic [QW-1:0] res;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, DW'(100 * (k + 1)), 1'b1, ixf, oxf, res, ov, ir, oo);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%0b exp=0", out_valid); end
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    while (guard < 12) begin
      cyc(guard == 0, 19'd5, 1'b1, ixf, oxf, res, ov, ir, oo);
      if (oxf) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL midrst_extra got=%0d exp=none", res); end
        else begin
          e = sb.pop_front();
          got++;
          if (res !== e.r) begin failures++; $display("FAIL midrst_value got=%0d exp=%0d", res, e.r); end
          checks++;
          if (cyc_n - e.c != 3) begin failures++; $display("FAIL midrst_latency got=%0d exp=3", cyc_n - e.c); end
        end
      end
      if (ixf) push_model(19'd5);
      guard++;
    end
    checks++; if (got != 1) begin failures++; $display("FAIL midrst_count got=%0d exp=1", got); end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_corner();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
